// File: rtl/sap_pkg.sv
// Shared opcode, T-state and control-word definitions
// for the SAP-1 style control sequencer.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  typedef struct packed {
    logic cp;
    logic ep;
    logic l_m;
    logic ce;
    logic l_i;
    logic e_i;
    logic l_a;
    logic e_a;
    logic l_b;
    logic s_u;
    logic e_u;
    logic l_o;
  } ctrl_t;

endpackage

// File: rtl/ring_counter6.sv
// Six-position one-hot T-state ring with a freeze input
// used while the machine is halted.
module ring_counter6
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  output logic [5:0] t_state
);

  always_ff @(posedge clk) begin
    if (reset)
      t_state <= T1;
    else if (!hold)
      t_state <= {t_state[4:0], t_state[5]};
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: T-state ring plus a
// zero-latency decode of T-state and opcode.
module control_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                Cp,
  output logic                Ep,
  output logic                L_M,
  output logic                CE,
  output logic                L_I,
  output logic                E_I,
  output logic                L_A,
  output logic                E_A,
  output logic                L_B,
  output logic                S_U,
  output logic                E_U,
  output logic                L_O,
  output logic                hlt,
  output logic [5:0]          t_state
);

  logic  halted;
  logic  hold;
  logic  is_lda, is_add, is_sub;
  logic  is_out, is_hlt;
  ctrl_t c;

  assign is_lda = opcode == OPCODE_W'(OP_LDA);
  assign is_add = opcode == OPCODE_W'(OP_ADD);
  assign is_sub = opcode == OPCODE_W'(OP_SUB);
  assign is_out = opcode == OPCODE_W'(OP_OUT);
  assign is_hlt = opcode == OPCODE_W'(OP_HLT);

  // Freeze already during the HLT T4 so the ring parks on T4.
  assign hold = halted | ((t_state == T4) & is_hlt);

  ring_counter6 u_ring (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (reset)
      halted <= 1'b0;
    else if ((t_state == T4) && is_hlt)
      halted <= 1'b1;
  end

  always_comb begin
    c = '0;
    if (!reset && !halted) begin
      unique case (1'b1)
        (t_state == T1): begin
          c.ep  = 1'b1;
          c.l_m = 1'b1;
        end
        (t_state == T2): begin
          c.cp = 1'b1;
        end
        (t_state == T3): begin
          c.ce  = 1'b1;
          c.l_i = 1'b1;
        end
        (t_state == T4): begin
          if (is_lda || is_add || is_sub) begin
            c.e_i = 1'b1;
            c.l_m = 1'b1;
          end else if (is_out) begin
            c.e_a = 1'b1;
            c.l_o = 1'b1;
          end
        end
        (t_state == T5): begin
          if (is_lda) begin
            c.ce  = 1'b1;
            c.l_a = 1'b1;
          end else if (is_add || is_sub) begin
            c.ce  = 1'b1;
            c.l_b = 1'b1;
          end
        end
        (t_state == T6): begin
          if (is_add || is_sub) begin
            c.e_u = 1'b1;
            c.l_a = 1'b1;
            c.s_u = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign Cp  = c.cp;
  assign Ep  = c.ep;
  assign L_M = c.l_m;
  assign CE  = c.ce;
  assign L_I = c.l_i;
  assign E_I = c.e_i;
  assign L_A = c.l_a;
  assign E_A = c.e_a;
  assign L_B = c.l_b;
  assign S_U = c.s_u;
  assign E_U = c.e_u;
  assign L_O = c.l_o;
  assign hlt = halted & ~reset;

endmodule
